// File: rtl/fsm_cond_pkg.sv
// fsm_cond_pkg: shared event layout and glitch counter constants
package fsm_cond_pkg;
  localparam int LVL1 = 0;
  localparam int LVL2 = 1;
  localparam int CHG1 = 2;
  localparam int CHG2 = 3;
  localparam int EVT_W = 4;
  localparam int GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: synchroniser, debounce counter and clean level register for one input
module debounce_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic chg,
  output logic abort
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic clean_q, clean_d, s;
  always_comb begin
    s = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    chg = (s != clean_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    abort = (s == clean_q) && (cnt_q != '0);
    cnt_d = (s == clean_q || chg) ? '0 : cnt_q + CW'(1);
    clean_d = chg ? s : clean_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      clean_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      clean_q <= clean_d;
    end
  end
  assign clean = clean_q;
endmodule

// File: rtl/fsm_input_conditioner.sv
// fsm_input_conditioner: debounces i1/i2, queues level-change events, counts rejected glitches
module fsm_input_conditioner
  import fsm_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i1_raw,
  input  logic i2_raw,
  output logic i1_clean,
  output logic i2_clean,
  output logic evt_valid,
  input  logic evt_ready,
  output logic [EVT_W-1:0] evt_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] evt_count,
  output logic overflow,
  input  logic ovf_clr,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  logic chg1, chg2, ab1, ab2, push, pop, wr, full;
  logic [EVT_W-1:0] entry;
  logic [EVT_W-1:0] mem_q [FIFO_DEPTH];
  logic [EVT_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [GLITCH_W:0] gsum;
  debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch1 (
    .clk(clk), .reset(reset), .raw(i1_raw), .clean(i1_clean), .chg(chg1), .abort(ab1)
  );
  debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch2 (
    .clk(clk), .reset(reset), .raw(i2_raw), .clean(i2_clean), .chg(chg2), .abort(ab2)
  );
  always_comb begin
    entry = '0;
    entry[CHG2] = chg2;
    entry[CHG1] = chg1;
    entry[LVL2] = i2_clean ^ chg2;
    entry[LVL1] = i1_clean ^ chg1;
    push = chg1 | chg2;
    full = count_q == CNTW'(FIFO_DEPTH);
    pop = (count_q != '0) && evt_ready;
    // a pop in the same cycle frees the slot the push needs
    wr = push && (!full || pop);
    mem_d = mem_q;
    if (wr) mem_d[wptr_q] = entry;
    wptr_d = wr ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CNTW'(wr) - CNTW'(pop);
    overflow_d = (push && !wr) ? 1'b1 : ovf_clr ? 1'b0 : overflow_q;
    gsum = {1'b0, glitch_q} + (GLITCH_W+1)'(ab1) + (GLITCH_W+1)'(ab2);
    glitch_d = gsum[GLITCH_W] ? GLITCH_MAX : gsum[GLITCH_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      glitch_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      glitch_q <= glitch_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign evt_valid = count_q != '0;
  assign evt_data = evt_valid ? mem_q[rptr_q] : '0;
  assign evt_count = count_q;
  assign overflow = overflow_q;
  assign glitch_cnt = glitch_q;
endmodule

// File: tb/tb_fsm_input_conditioner.sv
// tb_fsm_input_conditioner: directed and random stimulus checked against a queue-based reference model
module tb_fsm_input_conditioner;
  localparam int SYNC = 2;
  localparam int DEB = 16;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset, i1_raw, i2_raw, evt_ready, ovf_clr;
  logic i1_clean, i2_clean, evt_valid, overflow;
  logic [3:0] evt_data;
  logic [2:0] evt_count;
  logic [7:0] glitch_cnt;
  int checks = 0;
  int errors = 0;
  bit syn1[$];
  bit syn2[$];
  bit m_clean[2];
  int m_run[2];
  int m_glitch;
  logic [3:0] m_fifo[$];
  bit m_ovf;
  fsm_input_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .i1_raw(i1_raw), .i2_raw(i2_raw), .i1_clean(i1_clean),
    .i2_clean(i2_clean), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_count(evt_count), .overflow(overflow), .ovf_clr(ovf_clr), .glitch_cnt(glitch_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_edge();
    bit s[2];
    bit chg[2];
    bit drop;
    if (reset) begin
      syn1.delete();
      syn2.delete();
      for (int i = 0; i < SYNC; i++) begin
        syn1.push_back(1'b0);
        syn2.push_back(1'b0);
      end
      m_clean = '{0, 0};
      m_run = '{0, 0};
      m_glitch = 0;
      m_fifo.delete();
      m_ovf = 0;
      return;
    end
    s[0] = syn1[0];
    s[1] = syn2[0];
    syn1.push_back(i1_raw);
    void'(syn1.pop_front());
    syn2.push_back(i2_raw);
    void'(syn2.pop_front());
    for (int c = 0; c < 2; c++) begin
      chg[c] = 0;
      if (s[c] == m_clean[c]) begin
        if (m_run[c] > 0) m_glitch = (m_glitch >= 255) ? 255 : m_glitch + 1;
        m_run[c] = 0;
      end else if (m_run[c] == DEB - 1) begin
        m_clean[c] = s[c];
        chg[c] = 1;
        m_run[c] = 0;
      end else begin
        m_run[c]++;
      end
    end
    if (m_fifo.size() > 0 && evt_ready) void'(m_fifo.pop_front());
    drop = 0;
    if (chg[0] || chg[1]) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back({chg[1], chg[0], m_clean[1], m_clean[0]});
      else drop = 1;
    end
    m_ovf = drop ? 1'b1 : ovf_clr ? 1'b0 : m_ovf;
  endtask
  task automatic compare_all();
    check("i1_clean", int'(i1_clean), int'(m_clean[0]));
    check("i2_clean", int'(i2_clean), int'(m_clean[1]));
    check("evt_valid", int'(evt_valid), int'(m_fifo.size() > 0));
    check("evt_data", int'(evt_data), m_fifo.size() > 0 ? int'(m_fifo[0]) : 0);
    check("evt_count", int'(evt_count), m_fifo.size());
    check("overflow", int'(overflow), int'(m_ovf));
    check("glitch_cnt", int'(glitch_cnt), m_glitch);
  endtask
  task automatic step(input bit r1, input bit r2, input bit rdy, input bit clr, input bit rst);
    i1_raw = r1;
    i2_raw = r2;
    evt_ready = rdy;
    ovf_clr = clr;
    reset = rst;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask
  task automatic hold(input bit r1, input bit r2, input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(r1, r2, rdy, 0, 0);
  endtask
  initial begin
    int n;
    int cd1, cd2;
    bit r1, r2;
    logic [3:0] exp_ev[4];
    exp_ev = '{4'h5, 4'h4, 4'h5, 4'h4};
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("reset_clean1", int'(i1_clean), 0);
    check("reset_count", int'(evt_count), 0);
    check("reset_glitch", int'(glitch_cnt), 0);
    // single rising edge: commit latency and event contents
    n = 0;
    do begin
      step(1, 0, 0, 0, 0);
      n++;
    end while (!i1_clean && n < 40);
    check("t1_latency", n, SYNC + DEB);
    step(1, 0, 0, 0, 0);
    check("t1_evt_data", int'(evt_data), 5);
    check("t1_evt_valid", int'(evt_valid), 1);
    // short pulse on i2 is rejected
    step(0, 0, 0, 0, 1);
    hold(0, 1, 0, 10);
    hold(0, 0, 0, 30);
    check("t2_clean2", int'(i2_clean), 0);
    check("t2_count", int'(evt_count), 0);
    check("t2_glitch", int'(glitch_cnt), 1);
    // simultaneous commit forms one event
    step(0, 0, 0, 0, 1);
    hold(1, 1, 0, SYNC + DEB + 2);
    check("t3_evt_data", int'(evt_data), 15);
    check("t3_count", int'(evt_count), 1);
    // overflow on the fifth event, ordered drain, then clear
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) hold(k % 2 == 0, 0, 0, 20);
    check("t4_count", int'(evt_count), 4);
    check("t4_overflow", int'(overflow), 1);
    for (int k = 0; k < 4; k++) begin
      check("t4_pop_data", int'(evt_data), int'(exp_ev[k]));
      step(1, 0, 1, 0, 0);
    end
    check("t4_empty", int'(evt_valid), 0);
    check("t4_ovf_before_clr", int'(overflow), 1);
    step(1, 0, 0, 1, 0);
    check("t4_ovf_clr", int'(overflow), 0);
    // push and pop on the same edge while full
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) hold(k % 2 == 0, 0, 0, 20);
    check("t5_full", int'(evt_count), 4);
    hold(1, 0, 0, SYNC + DEB - 1);
    step(1, 0, 1, 0, 0);
    check("t5_commit", int'(i1_clean), 1);
    check("t5_count", int'(evt_count), 4);
    check("t5_overflow", int'(overflow), 0);
    // reset mid-debounce with two entries queued
    step(0, 0, 0, 0, 1);
    hold(1, 0, 0, 20);
    hold(0, 0, 0, 20);
    check("t6_pre_count", int'(evt_count), 2);
    hold(1, 0, 0, 10);
    step(1, 0, 0, 0, 1);
    check("t6_count", int'(evt_count), 0);
    check("t6_valid", int'(evt_valid), 0);
    check("t6_data", int'(evt_data), 0);
    check("t6_glitch", int'(glitch_cnt), 0);
    check("t6_clean1", int'(i1_clean), 0);
    step(0, 0, 0, 0, 0);
    check("t6_glitch_after", int'(glitch_cnt), 0);
    // randomized soak
    r1 = 0;
    r2 = 0;
    cd1 = 1;
    cd2 = 1;
    for (int i = 0; i < 3000; i++) begin
      if (--cd1 <= 0) begin r1 = ~r1; cd1 = $urandom_range(1, 30); end
      if (--cd2 <= 0) begin r2 = ~r2; cd2 = $urandom_range(1, 30); end
      step(r1, r2, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
    end
    // glitch counter saturation, both channels aborting together
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      hold(1, 1, 0, 3);
      hold(0, 0, 0, 3);
    end
    check("sat_glitch", int'(glitch_cnt), 255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
